// File: rtl/alu_mdu_ctrl_if.sv
// EX-stage bus between the pipeline and the ALU/multiply control block.
// The pipeline drives the decode fields and operands (master).
// The control block returns the ALU select, the multiply status and the product (slave).
interface alu_mdu_ctrl_if #(
  parameter int WIDTH = 32
);
  // Instruction fields and operands coming from the EX stage
  logic             valid_i;
  logic             flush_i;
  logic [5:0]       funct_i;
  logic [1:0]       ALUOp_i;
  logic [WIDTH-1:0] rs_data_i;
  logic [WIDTH-1:0] rt_data_i;

  // Decode results and multiply status going back to the pipeline
  logic [2:0]       ALUCtrl_o;
  logic             illegal_o;
  logic             is_mul_o;
  logic             mdu_busy_o;
  logic             mdu_done_o;
  logic [WIDTH-1:0] mdu_result_o;

  // EX stage / hazard-unit side
  modport master (
    output valid_i, flush_i, funct_i, ALUOp_i, rs_data_i, rt_data_i,
    input  ALUCtrl_o, illegal_o, is_mul_o, mdu_busy_o, mdu_done_o, mdu_result_o
  );

  // Control block side
  modport slave (
    input  valid_i, flush_i, funct_i, ALUOp_i, rs_data_i, rt_data_i,
    output ALUCtrl_o, illegal_o, is_mul_o, mdu_busy_o, mdu_done_o, mdu_result_o
  );
endinterface

// File: rtl/alu_mdu_ctrl.sv
// ALU control for the EX stage of the pipelined MIPS core.
// ALUOp/funct decode is combinational. The mul funct is not sent to the
// single-cycle ALU: it runs in a local shift-add multiplier that retires
// BITS_PER_CYCLE multiplier bits per clock. The hazard unit is stalled
// through mdu_busy_o until the one-cycle mdu_done_o pulse.
module alu_mdu_ctrl #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1    // 1, 2, 4 or 8; must divide WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_mdu_ctrl_if.slave bus
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SLT = 3'b011;
  localparam logic [2:0] CTRL_SUB = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] result_q;
  logic             done_q;

  logic [2:0]       alu_ctrl;
  logic             illegal;
  logic             is_mul;
  logic             accept;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] acc_d;

  // Partial-product terms: one shifted copy of the multiplicand per
  // multiplier bit retired this cycle, zero when that bit is clear.
  logic [WIDTH-1:0] pp_terms [BITS_PER_CYCLE];

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
      assign pp_terms[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
    end
  endgenerate

  // ALUOp/funct decode; unknown functs fall back to add and flag illegal
  always_comb begin
    alu_ctrl = CTRL_ADD;
    illegal  = 1'b0;
    is_mul   = 1'b0;
    case (bus.ALUOp_i)
      2'b00: alu_ctrl = CTRL_ADD;
      2'b01: alu_ctrl = CTRL_SUB;
      default: begin
        case (bus.funct_i)
          FUNCT_ADD: alu_ctrl = CTRL_ADD;
          FUNCT_SUB: alu_ctrl = CTRL_SUB;
          FUNCT_AND: alu_ctrl = CTRL_AND;
          FUNCT_OR:  alu_ctrl = CTRL_OR;
          FUNCT_SLT: alu_ctrl = CTRL_SLT;
          FUNCT_MUL: begin
            alu_ctrl = CTRL_ADD;
            is_mul   = 1'b1;
          end
          default: begin
            alu_ctrl = CTRL_ADD;
            illegal  = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Sum the partial-product terms and fold them into the accumulator
  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      partial = partial + pp_terms[i];
    end
    acc_d = acc_q + partial;
  end

  assign accept = bus.valid_i & is_mul & ~bus.flush_i;

  // Multiply sequencer: IDLE -> MUL (STEPS updates) -> DONE -> IDLE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            mcand_q  <= bus.rs_data_i;
            mplier_q <= bus.rt_data_i;
            acc_q    <= '0;
            count_q  <= '0;
            state_q  <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (bus.flush_i) begin
            // Squashed instruction: drop the product, keep the old result
            state_q <= ST_IDLE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << BITS_PER_CYCLE;
            mplier_q <= mplier_q >> BITS_PER_CYCLE;
            count_q  <= count_q + CNT_W'(1);
            if (count_q == LAST_STEP) begin
              result_q <= acc_d;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // The mul sitting in EX now is the one completing, so never
          // re-accept here; a following mul starts next cycle.
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ALUCtrl_o    = alu_ctrl;
  assign bus.illegal_o    = illegal;
  assign bus.is_mul_o     = is_mul;
  assign bus.mdu_busy_o   = ((state_q == ST_IDLE) & accept) | (state_q == ST_MUL);
  assign bus.mdu_done_o   = done_q;
  assign bus.mdu_result_o = result_q;

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Directed bench for alu_mdu_ctrl: decode table, B=1 multiply latency and
// products, flush, asynchronous reset, and B=4 back-to-back multiplies.
module tb_alu_mdu_ctrl;

  localparam logic [5:0] F_MUL = 6'b011000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_mdu_ctrl_if #(.WIDTH(32)) bus_a ();
  alu_mdu_ctrl_if #(.WIDTH(32)) bus_b ();

  alu_mdu_ctrl #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a.slave)
  );

  alu_mdu_ctrl #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus_a.mdu_busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %0b expected 0", bus_a.mdu_busy_o);
    end
    checks++;
    if (bus_a.mdu_done_o !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %0b expected 0", bus_a.mdu_done_o);
    end
    checks++;
    if (bus_a.mdu_result_o !== 32'h0) begin
      errors++; $display("FAIL reset_result: got %08h expected 00000000", bus_a.mdu_result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (bus_a.mdu_busy_o !== 1'b0 || bus_a.mdu_done_o !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got busy=%0b done=%0b expected 0 0",
                         bus_a.mdu_busy_o, bus_a.mdu_done_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_decode();
    logic [1:0] ops   [10] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b00};
    logic [5:0] fns   [10] = '{6'b000000, 6'b100000, 6'b100000, 6'b100010, 6'b100100,
                               6'b100101, 6'b101010, 6'b011000, 6'b111111, 6'b111111};
    logic [2:0] ctl   [10] = '{3'b010, 3'b110, 3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b010, 3'b010, 3'b010};
    logic       ill   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       mul   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus_a.valid_i = 1'b0;
      bus_a.ALUOp_i = ops[i];
      bus_a.funct_i = fns[i];
      #1;
      checks++;
      if (bus_a.ALUCtrl_o !== ctl[i] || bus_a.illegal_o !== ill[i] || bus_a.is_mul_o !== mul[i]) begin
        errors++;
        $display("FAIL decode[%0d]: got ctrl=%03b ill=%0b mul=%0b expected ctrl=%03b ill=%0b mul=%0b",
                 i, bus_a.ALUCtrl_o, bus_a.illegal_o, bus_a.is_mul_o, ctl[i], ill[i], mul[i]);
      end
      $display("decode ALUOp=%02b funct=%06b ctrl=%03b ill=%0b mul=%0b",
               ops[i], fns[i], bus_a.ALUCtrl_o, bus_a.illegal_o, bus_a.is_mul_o);
    end
    // Illegal funct with a valid instruction must not start the multiplier
    tick();
    bus_a.valid_i = 1'b1;
    bus_a.ALUOp_i = 2'b10;
    bus_a.funct_i = 6'b111111;
    #1;
    checks++;
    if (bus_a.mdu_busy_o !== 1'b0 || bus_a.illegal_o !== 1'b1) begin
      errors++; $display("FAIL decode_illegal_busy: got busy=%0b ill=%0b expected 0 1",
                         bus_a.mdu_busy_o, bus_a.illegal_o);
    end
    tick();
    bus_a.valid_i = 1'b0;
    #1;
    checks++;
    if (bus_a.mdu_busy_o !== 1'b0) begin
      errors++; $display("FAIL decode_illegal_nostart: got busy=%0b expected 0", bus_a.mdu_busy_o);
    end
  endtask

  // One B=1 multiply: accept in cycle 0, busy 0..32, done in cycle 33
  task automatic test_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    int busy_cnt;
    int done_at;
    busy_cnt = 0;
    done_at  = -1;
    tick();
    bus_a.valid_i   = 1'b1;
    bus_a.flush_i   = 1'b0;
    bus_a.ALUOp_i   = 2'b10;
    bus_a.funct_i   = F_MUL;
    bus_a.rs_data_i = a;
    bus_a.rt_data_i = b;
    #1;
    for (int c = 0; c < 100 && done_at < 0; c++) begin
      if (c > 0) begin
        tick();
        #1;
      end
      if (c == 3) begin
        // Operands are latched; later changes must be ignored
        bus_a.rs_data_i = 32'hDEADBEEF;
        bus_a.rt_data_i = 32'h0BADF00D;
      end
      if (bus_a.mdu_busy_o === 1'b1) busy_cnt++;
      if (bus_a.mdu_done_o === 1'b1) begin
        done_at = c;
        bus_a.valid_i = 1'b0;
      end
    end
    checks++;
    if (busy_cnt != 33) begin
      errors++; $display("FAIL %s_busy_cycles: got %0d expected 33", name, busy_cnt);
    end
    checks++;
    if (done_at != 33) begin
      errors++; $display("FAIL %s_done_cycle: got %0d expected 33", name, done_at);
    end
    checks++;
    if (bus_a.mdu_result_o !== exp) begin
      errors++; $display("FAIL %s_result: got %08h expected %08h", name, bus_a.mdu_result_o, exp);
    end
    tick();
    #1;
    checks++;
    if (bus_a.mdu_done_o !== 1'b0 || bus_a.mdu_result_o !== exp) begin
      errors++; $display("FAIL %s_hold: got done=%0b result=%08h expected done=0 result=%08h",
                         name, bus_a.mdu_done_o, bus_a.mdu_result_o, exp);
    end
    $display("mul %s %08h*%08h -> %08h busy=%0d done@%0d", name, a, b,
             bus_a.mdu_result_o, busy_cnt, done_at);
  endtask

  task automatic test_flush();
    bit saw_done;
    // Flush in cycle 10 of a running multiply
    tick();
    bus_a.valid_i   = 1'b1;
    bus_a.ALUOp_i   = 2'b10;
    bus_a.funct_i   = F_MUL;
    bus_a.rs_data_i = 32'd3;
    bus_a.rt_data_i = 32'd5;
    for (int c = 1; c <= 10; c++) tick();
    bus_a.flush_i = 1'b1;
    #1;
    checks++;
    if (bus_a.mdu_busy_o !== 1'b1) begin
      errors++; $display("FAIL flush_busy_before: got %0b expected 1", bus_a.mdu_busy_o);
    end
    tick();
    bus_a.valid_i = 1'b0;
    bus_a.flush_i = 1'b0;
    #1;
    checks++;
    if (bus_a.mdu_busy_o !== 1'b0) begin
      errors++; $display("FAIL flush_busy_after: got %0b expected 0", bus_a.mdu_busy_o);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus_a.mdu_done_o === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL flush_no_done: got done pulse expected none");
    end
    checks++;
    if (bus_a.mdu_result_o !== 32'h0000002A) begin
      errors++; $display("FAIL flush_result: got %08h expected 0000002a", bus_a.mdu_result_o);
    end
    $display("flush mid-mul: busy=%0b result=%08h", bus_a.mdu_busy_o, bus_a.mdu_result_o);

    // Flush together with a would-be accept in IDLE
    tick();
    bus_a.valid_i   = 1'b1;
    bus_a.flush_i   = 1'b1;
    bus_a.rs_data_i = 32'd9;
    bus_a.rt_data_i = 32'd9;
    #1;
    checks++;
    if (bus_a.mdu_busy_o !== 1'b0) begin
      errors++; $display("FAIL flush_idle_busy: got %0b expected 0", bus_a.mdu_busy_o);
    end
    tick();
    bus_a.valid_i = 1'b0;
    bus_a.flush_i = 1'b0;
    #1;
    checks++;
    if (bus_a.mdu_busy_o !== 1'b0) begin
      errors++; $display("FAIL flush_idle_nostart: got %0b expected 0", bus_a.mdu_busy_o);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus_a.mdu_done_o === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || bus_a.mdu_result_o !== 32'h0000002A) begin
      errors++; $display("FAIL flush_idle_result: got done=%0b result=%08h expected 0 0000002a",
                         saw_done, bus_a.mdu_result_o);
    end
    $display("flush in idle: result=%08h", bus_a.mdu_result_o);
  endtask

  task automatic test_async_reset();
    tick();
    bus_a.valid_i   = 1'b1;
    bus_a.ALUOp_i   = 2'b10;
    bus_a.funct_i   = F_MUL;
    bus_a.rs_data_i = 32'h10;
    bus_a.rt_data_i = 32'h10;
    for (int c = 1; c <= 5; c++) tick();
    checks++;
    if (bus_a.mdu_busy_o !== 1'b1 || bus_a.mdu_result_o !== 32'h1) begin
      errors++; $display("FAIL areset_pre: got busy=%0b result=%08h expected 1 00000001",
                         bus_a.mdu_busy_o, bus_a.mdu_result_o);
    end
    // Assert reset between clock edges and look before the next edge
    #1;
    rst           = 1'b1;
    bus_a.valid_i = 1'b0;
    #1;
    checks++;
    if (bus_a.mdu_busy_o !== 1'b0 || bus_a.mdu_done_o !== 1'b0 || bus_a.mdu_result_o !== 32'h0) begin
      errors++; $display("FAIL areset_outputs: got busy=%0b done=%0b result=%08h expected 0 0 00000000",
                         bus_a.mdu_busy_o, bus_a.mdu_done_o, bus_a.mdu_result_o);
    end
    $display("async reset: busy=%0b done=%0b result=%08h",
             bus_a.mdu_busy_o, bus_a.mdu_done_o, bus_a.mdu_result_o);
    @(negedge clk);
    rst = 1'b0;
    test_mul("after_reset", 32'd7, 32'd6, 32'h0000002A);
  endtask

  task automatic test_back_to_back();
    int phase;
    int cnt0;
    int cnt1;
    int done0;
    int done1;
    int first1;
    logic [31:0] res0;
    logic [31:0] res1;
    phase  = 0;
    cnt0   = 0;
    cnt1   = 0;
    done0  = -1;
    done1  = -1;
    first1 = -1;
    res0   = '0;
    res1   = '0;
    tick();
    bus_b.valid_i   = 1'b1;
    bus_b.flush_i   = 1'b0;
    bus_b.ALUOp_i   = 2'b10;
    bus_b.funct_i   = F_MUL;
    bus_b.rs_data_i = 32'd1000;
    bus_b.rt_data_i = 32'd1000;
    #1;
    for (int c = 0; c < 60 && done1 < 0; c++) begin
      if (c > 0) begin
        tick();
        #1;
      end
      if (phase == 0) begin
        if (bus_b.mdu_busy_o === 1'b1) cnt0++;
        if (bus_b.mdu_done_o === 1'b1) begin
          done0 = c;
          res0  = bus_b.mdu_result_o;
          bus_b.rs_data_i = 32'h00010001;
          bus_b.rt_data_i = 32'h00010001;
          phase = 1;
        end
      end else begin
        if (bus_b.mdu_busy_o === 1'b1) begin
          cnt1++;
          if (first1 < 0) first1 = c;
        end
        if (bus_b.mdu_done_o === 1'b1) begin
          done1 = c;
          res1  = bus_b.mdu_result_o;
          bus_b.valid_i = 1'b0;
        end
      end
    end
    checks++;
    if (cnt0 != 9 || done0 != 9) begin
      errors++; $display("FAIL b2b_first_timing: got busy=%0d done@%0d expected 9 9", cnt0, done0);
    end
    checks++;
    if (res0 !== 32'h000F4240) begin
      errors++; $display("FAIL b2b_first_result: got %08h expected 000f4240", res0);
    end
    checks++;
    if (first1 != 10) begin
      errors++; $display("FAIL b2b_second_accept: got cycle %0d expected 10", first1);
    end
    checks++;
    if (cnt1 != 9 || done1 != 19) begin
      errors++; $display("FAIL b2b_second_timing: got busy=%0d done@%0d expected 9 19", cnt1, done1);
    end
    checks++;
    if (res1 !== 32'h00020001) begin
      errors++; $display("FAIL b2b_second_result: got %08h expected 00020001", res1);
    end
    $display("b2b B=4: %08h busy=%0d done@%0d, %08h busy=%0d accept@%0d done@%0d",
             res0, cnt0, done0, res1, cnt1, first1, done1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst    = 1'b1;
    bus_a.valid_i = 1'b0; bus_a.flush_i = 1'b0; bus_a.funct_i = '0; bus_a.ALUOp_i = '0;
    bus_a.rs_data_i = '0; bus_a.rt_data_i = '0;
    bus_b.valid_i = 1'b0; bus_b.flush_i = 1'b0; bus_b.funct_i = '0; bus_b.ALUOp_i = '0;
    bus_b.rs_data_i = '0; bus_b.rt_data_i = '0;

    test_reset();
    test_decode();
    test_mul("7x6", 32'd7, 32'd6, 32'h0000002A);
    test_flush();
    test_mul("zero", 32'h0, 32'h12345678, 32'h0);
    test_mul("neg3x5", 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1);
    test_mul("allones", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    test_async_reset();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
